// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP16 adder among four requesters.
// Latency LAT cycles grant-to-response; responses have no backpressure, grants stop when en is low.
module fp16_add_arbiter #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  req_valid,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [3:0]  req_ready,
  output logic        add_valid,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_result,
  output logic        resp_valid,
  output logic [1:0]  resp_id,
  output logic [15:0] resp_data,
  output logic        busy,
  output logic [15:0] issue_cnt,
  output logic [15:0] skip_cnt,
  input  logic        clr_stats
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [1:0]  rr_ptr;
  logic [3:0]  inflight;
  logic [3:0]  grant;
  logic [1:0]  gnt_id;
  logic [1:0]  cand;
  logic        found;
  logic        xfer;
  logic [15:0] sel_a, sel_b;
  logic        a_zero, b_zero, op_zero;
  logic [15:0] skip_res;

  logic        pv    [LAT];
  logic [1:0]  pid   [LAT];
  logic        pskip [LAT];
  logic [15:0] pres  [LAT];

  // First valid requester strictly after the last grant, wrapping 3->0.
  always_comb begin
    grant  = '0;
    gnt_id = rr_ptr;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr + k[1:0];
      if (!found && req_valid[cand]) begin
        grant[cand] = 1'b1;
        gnt_id      = cand;
        found       = 1'b1;
      end
    end
  end

  assign req_ready = (state == S_RUN && en) ? grant : 4'b0000;
  assign xfer      = |(req_valid & req_ready);

  assign sel_a   = req_a[gnt_id*16 +: 16];
  assign sel_b   = req_b[gnt_id*16 +: 16];
  assign a_zero  = (sel_a[14:0] == 15'd0);
  assign b_zero  = (sel_b[14:0] == 15'd0);
  assign op_zero = a_zero | b_zero;

  always_comb begin
    skip_res = {sel_a[15] & sel_b[15], 15'd0};
    if (a_zero && !b_zero)
      skip_res = sel_b;
    else if (b_zero && !a_zero)
      skip_res = sel_a;
  end

  assign add_valid = xfer & ~op_zero;
  assign add_a     = add_valid ? sel_a : 16'd0;
  assign add_b     = add_valid ? sel_b : 16'd0;

  assign resp_valid = pv[LAT-1];
  assign resp_id    = pv[LAT-1] ? pid[LAT-1] : 2'd0;
  assign resp_data  = !pv[LAT-1] ? 16'd0 : (pskip[LAT-1] ? pres[LAT-1] : add_result);
  assign busy       = (state != S_IDLE) || (inflight != 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN:   if (!en) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (en)
          state_nxt = S_RUN;
        else if (inflight == 4'd0)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= 2'd3;
      inflight <= 4'd0;
    end else begin
      state <= state_nxt;
      if (xfer)
        rr_ptr <= gnt_id;
      case ({xfer, resp_valid})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Tag pipeline: one slot per cycle so responses leave exactly LAT cycles after grant, in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i]    <= 1'b0;
        pid[i]   <= 2'd0;
        pskip[i] <= 1'b0;
        pres[i]  <= 16'd0;
      end
    end else begin
      pv[0]    <= xfer;
      pid[0]   <= gnt_id;
      pskip[0] <= op_zero;
      pres[0]  <= skip_res;
      for (int i = 1; i < LAT; i++) begin
        pv[i]    <= pv[i-1];
        pid[i]   <= pid[i-1];
        pskip[i] <= pskip[i-1];
        pres[i]  <= pres[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= 16'd0;
      skip_cnt  <= 16'd0;
    end else if (clr_stats) begin
      issue_cnt <= 16'd0;
      skip_cnt  <= 16'd0;
    end else begin
      if (add_valid && issue_cnt != 16'hFFFF)
        issue_cnt <= issue_cnt + 16'd1;
      if (xfer && op_zero && skip_cnt != 16'hFFFF)
        skip_cnt <= skip_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Randomized and directed bench for fp16_add_arbiter with a scoreboard fed by a spec-level model.
module tb_fp16_add_arbiter;
  localparam int LAT = 3;

  logic        clk, rst_n, en, clr_stats;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic        add_valid, resp_valid, busy;
  logic [15:0] add_a, add_b, add_result, resp_data, issue_cnt, skip_cnt;
  logic [1:0]  resp_id;

  fp16_add_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .issue_cnt(issue_cnt), .skip_cnt(skip_cnt), .clr_stats(clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in for the external adder: a fixed-latency function of its operands.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
    return a ^ {b[7:0], b[15:8]} ^ 16'h5A5A;
  endfunction

  logic [15:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= fadd(add_a, add_b);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_result = apipe[LAT-1];

  // Reference model
  function automatic bit is_zero(input logic [15:0] x);
    return x[14:0] == 15'd0;
  endfunction

  function automatic logic [15:0] skip_value(input logic [15:0] a, input logic [15:0] b);
    if (is_zero(a) && !is_zero(b)) return b;
    if (is_zero(b) && !is_zero(a)) return a;
    return {a[15] & b[15], 15'd0};
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (ptr + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          act_grants[$];
  int          act_resps[$];
  int          m_state, m_ptr, m_issue, m_skip;
  int          g, q0;
  logic [3:0]  exp_rdy;
  logic [15:0] ma, mb;
  bit          mskip, madd;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("reset_outputs",
            {req_ready, add_valid, add_a, add_b, resp_valid, resp_id, resp_data, busy, issue_cnt, skip_cnt},
            96'd0);
      m_state = 0; m_ptr = 3; m_issue = 0; m_skip = 0;
      sb.delete();
    end else begin
      q0 = sb.size();
      exp_rdy = 4'b0000;
      g = -1;
      if (m_state == 1 && en) g = rr_pick(req_valid, m_ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      for (int i = 0; i < 4; i++) if (req_ready[i]) act_grants.push_back(i);

      ma = 16'd0; mb = 16'd0; mskip = 0; madd = 0;
      if (g >= 0) begin
        ma = req_a[g*16 +: 16];
        mb = req_b[g*16 +: 16];
        mskip = is_zero(ma) || is_zero(mb);
        madd  = !mskip;
      end
      check("add_valid", add_valid, madd);
      check("add_ops", {add_a, add_b}, madd ? {ma, mb} : 32'd0);
      check("busy", busy, (m_state != 0) || (q0 != 0));
      check("issue_cnt", issue_cnt, m_issue);
      check("skip_cnt", skip_cnt, m_skip);

      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("resp_valid", resp_valid, 1'b1);
        if (resp_valid) begin
          check("resp_id", resp_id, sb[0].id);
          check("resp_data", resp_data, sb[0].data);
        end
        void'(sb.pop_front());
      end else begin
        check("resp_valid_idle", resp_valid, 1'b0);
      end
      if (resp_valid) act_resps.push_back(int'(resp_id));

      if (clr_stats) begin
        m_issue = 0; m_skip = 0;
      end else begin
        if (madd && m_issue < 65535) m_issue++;
        if (mskip && m_skip < 65535) m_skip++;
      end
      if (g >= 0) begin
        e.id   = g;
        e.data = mskip ? skip_value(ma, mb) : fadd(ma, mb);
        e.due  = cyc + LAT;
        sb.push_back(e);
        m_ptr = g;
      end
      case (m_state)
        0: if (en) m_state = 1;
        1: if (!en) m_state = 2;
        default: if (en) m_state = 1; else if (q0 == 0) m_state = 0;
      endcase
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int n);
    int budget;
    budget = 0;
    while (act_grants.size() < n && budget < 50) begin
      tick();
      budget++;
    end
    if (act_grants.size() < n) check("grant_timeout", act_grants.size(), n);
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'b0000;
    en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr_stats = 1'b0;
    req_valid = 4'b0000; req_a = 64'd0; req_b = 64'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single add
    act_grants.delete(); act_resps.delete();
    set_req(0, 16'h3C00, 16'h4000);
    req_valid = 4'b0001; en = 1'b1;
    wait_grants(1);
    req_valid = 4'b0000;
    repeat (LAT + 1) tick();
    check("single_grant", act_grants.size() > 0 ? act_grants[0] : -1, 0);
    check("single_resp_cnt", act_resps.size(), 1);
    check("single_issue_cnt", issue_cnt, 1);

    // Fairness from reset
    do_reset();
    act_grants.delete(); act_resps.delete();
    for (int i = 0; i < 4; i++) set_req(i, 16'h3800 + 16'(i), 16'h4400 + 16'(i));
    en = 1'b1; req_valid = 4'b1111;
    wait_grants(8);
    req_valid = 4'b0000;
    repeat (LAT + 2) tick();
    for (int i = 0; i < 8; i++) begin
      check("fair_grant", i < act_grants.size() ? act_grants[i] : -1, i % 4);
      check("fair_resp", i < act_resps.size() ? act_resps[i] : -1, i % 4);
    end

    // Zero-operand skips
    act_grants.delete();
    set_req(2, 16'h0000, 16'hC500);
    req_valid = 4'b0100;
    wait_grants(1);
    req_valid = 4'b0000;
    set_req(3, 16'h8000, 16'h8000);
    req_valid = 4'b1000;
    wait_grants(2);
    req_valid = 4'b0000;
    repeat (LAT + 1) tick();
    check("skip_cnt_two", skip_cnt, 2);

    // Drain with three in flight
    act_grants.delete();
    req_valid = 4'b1111;
    wait_grants(5);
    en = 1'b0;
    repeat (LAT + 4) tick();
    req_valid = 4'b0000;
    check("drain_busy", busy, 1'b0);

    // Reset with two in flight
    act_grants.delete(); act_resps.delete();
    en = 1'b1; req_valid = 4'b1111;
    wait_grants(2);
    do_reset();
    repeat (LAT + 2) tick();
    check("rst_no_resp", act_resps.size(), 0);
    check("rst_busy", busy, 1'b0);
    act_grants.delete();
    en = 1'b1; req_valid = 4'b1111;
    wait_grants(1);
    req_valid = 4'b0000;
    check("rst_first_grant", act_grants.size() > 0 ? act_grants[0] : -1, 0);
    repeat (LAT + 1) tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      en = ($urandom % 8) != 0;
      req_valid = 4'($urandom);
      clr_stats = ($urandom % 50) == 0;
      for (int i = 0; i < 4; i++) begin
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        if ($urandom % 5 == 0) a[14:0] = 15'd0;
        if ($urandom % 5 == 0) b[14:0] = 15'd0;
        set_req(i, a, b);
      end
      tick();
    end
    clr_stats = 1'b0;

    // Counter saturation and clear priority
    for (int i = 0; i < 4; i++) set_req(i, 16'h3C00, 16'h4000);
    en = 1'b1; req_valid = 4'b1111; clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    repeat (65545) tick();
    check("issue_saturate", issue_cnt, 16'hFFFF);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_over_issue", issue_cnt, 16'd0);
    req_valid = 4'b0000; en = 1'b0;
    repeat (LAT + 4) tick();
    check("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
